// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the register-file write port: NUM_REQ writeback sources
// compete, and one winner per cycle is registered onto the write port.
module wb_port_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 5,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      write_reg,
  output logic [ADDR_W-1:0]         target_reg,
  output logic [DATA_W-1:0]         write_rd_data,
  output logic [ID_W-1:0]           grant_id
);

  logic [ID_W-1:0]    r_last_grant;
  logic               r_write_reg;
  logic [ADDR_W-1:0]  r_target_reg;
  logic [DATA_W-1:0]  r_write_rd_data;
  logic [ID_W-1:0]    r_grant_id;

  logic [NUM_REQ-1:0] w_is_x0;
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic               w_grant_any;
  logic [ID_W-1:0]    w_winner;
  logic [ADDR_W-1:0]  w_win_rd;
  logic [DATA_W-1:0]  w_win_data;

  // Writes to x0 are discarded by the register file, so they are acked
  // immediately and never take an arbitration slot.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_is_x0[i]    = req_valid[i] && (req_rd[i*ADDR_W +: ADDR_W] == '0);
      w_eligible[i] = req_valid[i] && (req_rd[i*ADDR_W +: ADDR_W] != '0)
                      && !stall && !rst;
    end
  end

  // Rank each requester by its distance past last_grant; lowest rank wins.
  always_comb begin
    int rank;
    int best;
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_grant_any = 1'b0;
    w_winner    = '0;
    best        = NUM_REQ;
    rank        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rank = i - int'(r_last_grant) - 1;
      if (rank < 0) rank = rank + NUM_REQ;
      if (w_eligible[i] && (rank < best)) begin
        best        = rank;
        w_grant_any = 1'b1;
        w_winner    = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_grant_oh = '0;
    w_win_rd   = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_any && (w_winner == ID_W'(i))) begin
        w_grant_oh[i] = 1'b1;
        w_win_rd      = req_rd[i*ADDR_W +: ADDR_W];
        w_win_data    = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = rst ? '0 : (w_is_x0 | w_grant_oh);

  // Idle cycles clear index and data so register-file bypass never matches
  // a stale destination; grant_id alone keeps its last value.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_last_grant    <= ID_W'(NUM_REQ - 1);
      r_write_reg     <= 1'b0;
      r_target_reg    <= '0;
      r_write_rd_data <= '0;
      r_grant_id      <= '0;
    end else if (w_grant_any) begin
      r_last_grant    <= w_winner;
      r_write_reg     <= 1'b1;
      r_target_reg    <= w_win_rd;
      r_write_rd_data <= w_win_data;
      r_grant_id      <= w_winner;
    end else begin
      r_write_reg     <= 1'b0;
      r_target_reg    <= '0;
      r_write_rd_data <= '0;
    end
  end

  assign write_reg     = r_write_reg;
  assign target_reg    = r_target_reg;
  assign write_rd_data = r_write_rd_data;
  assign grant_id      = r_grant_id;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with two requesters: reset, round-robin,
// single request, x0 filter, stall and reset during a would-be accept.
module tb_wb_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int ID_W    = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] rd0, rd1;
  logic [DATA_W-1:0] d0, d1;
  logic [NUM_REQ*ADDR_W-1:0] req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic              write_reg;
  logic [ADDR_W-1:0] target_reg;
  logic [DATA_W-1:0] write_rd_data;
  logic [ID_W-1:0]   grant_id;

  int n_checks = 0;
  int n_errors = 0;

  assign req_rd   = {rd1, rd0};
  assign req_data = {d1, d0};

  always #5 clk = ~clk;

  wb_port_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .write_reg(write_reg), .target_reg(target_reg),
    .write_rd_data(write_rd_data), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic wr, input logic [ADDR_W-1:0] tr,
                         input logic [DATA_W-1:0] dat, input logic [ID_W-1:0] gid);
    chk({tag, ".write_reg"},  32'(write_reg),     32'(wr));
    chk({tag, ".target_reg"}, 32'(target_reg),    32'(tr));
    chk({tag, ".data"},       write_rd_data,      dat);
    chk({tag, ".grant_id"},   32'(grant_id),      32'(gid));
  endtask

  initial begin
    // 1: reset held two edges with both requesters valid
    rst = 1'b1; stall = 1'b0; req_valid = 2'b11;
    rd0 = 5'd3; d0 = 32'hAAAA0001; rd1 = 5'd7; d1 = 32'hBBBB0002;
    @(negedge clk);
    chk("rst1.ready", 32'(req_ready), 32'b00);
    chk_out("rst1", 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst2.ready", 32'(req_ready), 32'b00);
    chk_out("rst2", 1'b0, 5'd0, 32'h0, 1'b0);

    // 2: both continuously valid -> 0,1,0,1
    rst = 1'b0; #1;
    chk("rr0.ready", 32'(req_ready), 32'b01);
    @(negedge clk);
    chk_out("rr0", 1'b1, 5'd3, 32'hAAAA0001, 1'b0);
    chk("rr1.ready", 32'(req_ready), 32'b10);
    @(negedge clk);
    chk_out("rr1", 1'b1, 5'd7, 32'hBBBB0002, 1'b1);
    chk("rr2.ready", 32'(req_ready), 32'b01);
    @(negedge clk);
    chk_out("rr2", 1'b1, 5'd3, 32'hAAAA0001, 1'b0);
    chk("rr3.ready", 32'(req_ready), 32'b10);
    @(negedge clk);
    chk_out("rr3", 1'b1, 5'd7, 32'hBBBB0002, 1'b1);

    // 3: only req1 valid for one cycle, then idle clears the port
    req_valid = 2'b10; rd1 = 5'd5; d1 = 32'h12345678; #1;
    chk("single.ready", 32'(req_ready), 32'b10);
    @(negedge clk);
    chk_out("single", 1'b1, 5'd5, 32'h12345678, 1'b1);
    req_valid = 2'b00;
    @(negedge clk);
    chk_out("idle", 1'b0, 5'd0, 32'h0, 1'b1);

    // 4: req0 targets x0, req1 targets 9 -> both ready, only rd 9 written
    req_valid = 2'b11; rd0 = 5'd0; d0 = 32'hDEAD0000; rd1 = 5'd9; d1 = 32'h00000099; #1;
    chk("x0.ready", 32'(req_ready), 32'b11);
    @(negedge clk);
    chk_out("x0", 1'b1, 5'd9, 32'h00000099, 1'b1);

    // 5: stall three cycles, then resume at last_grant+1 (req0)
    rd0 = 5'd3; d0 = 32'hAAAA0001; rd1 = 5'd7; d1 = 32'hBBBB0002; stall = 1'b1; #1;
    chk("stall0.ready", 32'(req_ready), 32'b00);
    @(negedge clk);
    chk_out("stall1", 1'b0, 5'd0, 32'h0, 1'b1);
    chk("stall1.ready", 32'(req_ready), 32'b00);
    @(negedge clk);
    chk_out("stall2", 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge clk);
    chk_out("stall3", 1'b0, 5'd0, 32'h0, 1'b1);
    stall = 1'b0; #1;
    chk("resume.ready", 32'(req_ready), 32'b01);
    @(negedge clk);
    chk_out("resume", 1'b1, 5'd3, 32'hAAAA0001, 1'b0);

    // 6: reset on the cycle req0 would be accepted drops the write
    req_valid = 2'b01; rst = 1'b1; #1;
    chk("rstmid.ready", 32'(req_ready), 32'b00);
    @(negedge clk);
    chk_out("rstmid", 1'b0, 5'd0, 32'h0, 1'b0);
    rst = 1'b0; req_valid = 2'b11; #1;
    chk("rstrel.ready", 32'(req_ready), 32'b01);
    @(negedge clk);
    chk_out("rstrel", 1'b1, 5'd3, 32'hAAAA0001, 1'b0);

    req_valid = 2'b00;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
